// File: rtl/rans_state_bank_pkg.sv
// rans_pkg: shared defaults and lane-index width helper for the rANS state bank
package rans_pkg;
    localparam int          STATE_W_DEF = 32;
    localparam logic [31:0] RANS_L_DEF  = 32'h0080_0000;
    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rans_lane_reg.sv
// rans_lane_reg: one rANS lane state register with reset, init load and write strobe
module rans_lane_reg import rans_pkg::*; #(
    parameter int W = STATE_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init_i,
    input  logic [W-1:0] init_val_i,
    input  logic         we_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] state_q, state_d;
    // init outranks a write; otherwise hold unless strobed
    always_comb begin
        state_d = init_i ? init_val_i : (we_i ? d_i : state_q);
    end
    // state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) state_q <= '0;
        else     state_q <= state_d;
    end
    assign q_o = state_q;
endmodule

// File: rtl/rans_state_bank.sv
// rans_state_bank: N interleaved rANS lane states, round-robin update; optional RANS_STATE_BANK_FINAL_CHECK_EN end-of-stream check
module rans_state_bank import rans_pkg::*; #(
    parameter int                 N_LANES = 4,
    parameter int                 STATE_W = STATE_W_DEF,
    parameter logic [STATE_W-1:0] RANS_L  = STATE_W'(RANS_L_DEF),
    parameter int                 CNT_W   = 16,
    localparam int                LW      = lane_w(N_LANES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       init,
    input  logic [N_LANES*STATE_W-1:0] init_vals,
    input  logic                       upd_valid,
    output logic                       upd_ready,
    input  logic [STATE_W-1:0]         upd_state,
    output logic [LW-1:0]              cur_lane,
    output logic [STATE_W-1:0]         cur_state,
    output logic                       cur_renorm,
    output logic                       lane_wrap,
    output logic [CNT_W-1:0]           upd_count,
    output logic                       final_ok
);
    logic [STATE_W-1:0] lane_q [N_LANES];
    logic [LW-1:0]      lane_ptr_q, lane_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wrap_q, wrap_d;
    logic               accept, last_lane;

    assign upd_ready = ~rst & ~init;
    assign accept    = upd_valid & upd_ready;
    assign last_lane = lane_ptr_q == LW'(N_LANES - 1);

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        rans_lane_reg #(.W(STATE_W)) u_lane (
            .clk        (clk),
            .rst        (rst),
            .init_i     (init),
            .init_val_i (init_vals[k*STATE_W +: STATE_W]),
            .we_i       (accept && lane_ptr_q == LW'(k)),
            .d_i        (upd_state),
            .q_o        (lane_q[k])
        );
    end

    // pointer advances round-robin, counter saturates, wrap flags an accept on the last lane
    always_comb begin
        lane_ptr_d = accept ? (last_lane ? '0 : lane_ptr_q + 1'b1) : lane_ptr_q;
        cnt_d      = (accept && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        wrap_d     = accept & last_lane;
    end
    // control registers; init clears them like reset
    always_ff @(posedge clk) begin
        if (rst || init) begin
            lane_ptr_q <= '0;
            cnt_q      <= '0;
            wrap_q     <= 1'b0;
        end else begin
            lane_ptr_q <= lane_ptr_d;
            cnt_q      <= cnt_d;
            wrap_q     <= wrap_d;
        end
    end

    assign cur_lane   = lane_ptr_q;
    assign cur_state  = lane_q[lane_ptr_q];
    assign cur_renorm = cur_state < RANS_L;
    assign lane_wrap  = wrap_q;
    assign upd_count  = cnt_q;

`ifdef RANS_STATE_BANK_FINAL_CHECK_EN
    logic [STATE_W-1:0] cap_q [N_LANES];
    logic               final_q, final_d;
    // evaluate the check on post-edge lane/pointer/counter values
    always_comb begin
        final_d = (lane_ptr_d == '0) && (cnt_d != '0);
        for (int i = 0; i < N_LANES; i++)
            final_d = final_d && (((accept && lane_ptr_q == LW'(i)) ? upd_state : lane_q[i]) == cap_q[i]);
    end
    // init values captured on init; the check result is registered
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q   <= '{default: '0};
            final_q <= 1'b0;
        end else if (init) begin
            for (int i = 0; i < N_LANES; i++) cap_q[i] <= init_vals[i*STATE_W +: STATE_W];
            final_q <= 1'b0;
        end else begin
            final_q <= final_d;
        end
    end
    assign final_ok = final_q;
`else
    assign final_ok = 1'b0;
`endif
endmodule

// File: tb/tb_rans_state_bank.sv
// tb_rans_state_bank: directed + model-checked bench for rans_state_bank (N=4) and a 1-lane, 2-bit-counter instance
module tb_rans_state_bank;
    localparam logic [31:0] RL = 32'h0080_0000;
`ifdef RANS_STATE_BANK_FINAL_CHECK_EN
    localparam bit FIN = 1'b1;
`else
    localparam bit FIN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, init, upd_valid;
    logic [127:0] init_vals;
    logic [31:0]  upd_state;
    logic         upd_ready, cur_renorm, lane_wrap, final_ok;
    logic [1:0]   cur_lane;
    logic [31:0]  cur_state;
    logic [15:0]  upd_count;
    logic         upd_ready2, cur_renorm2, lane_wrap2, final_ok2;
    logic [0:0]   cur_lane2;
    logic [31:0]  cur_state2;
    logic [1:0]   upd_count2;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    rans_state_bank dut (
        .clk(clk), .rst(rst), .init(init), .init_vals(init_vals),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_state(upd_state),
        .cur_lane(cur_lane), .cur_state(cur_state), .cur_renorm(cur_renorm),
        .lane_wrap(lane_wrap), .upd_count(upd_count), .final_ok(final_ok)
    );

    rans_state_bank #(.N_LANES(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .init(init), .init_vals(init_vals[31:0]),
        .upd_valid(upd_valid), .upd_ready(upd_ready2), .upd_state(upd_state),
        .cur_lane(cur_lane2), .cur_state(cur_state2), .cur_renorm(cur_renorm2),
        .lane_wrap(lane_wrap2), .upd_count(upd_count2), .final_ok(final_ok2)
    );

    logic [31:0] m_lane [4];
    logic [31:0] m_cap [4];
    int          m_ptr, m_cnt;
    bit          m_wrap;
    logic [31:0] m2_lane, m2_cap;
    int          m2_cnt;
    bit          m2_wrap;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: lanes as plain arrays, round-robin index, saturating count
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_lane[i] <= 32'd0;
                m_cap[i]  <= 32'd0;
            end
            m_ptr <= 0; m_cnt <= 0; m_wrap <= 1'b0;
            m2_lane <= 32'd0; m2_cap <= 32'd0; m2_cnt <= 0; m2_wrap <= 1'b0;
        end else if (init) begin
            for (int i = 0; i < 4; i++) begin
                m_lane[i] <= init_vals[i*32 +: 32];
                m_cap[i]  <= init_vals[i*32 +: 32];
            end
            m_ptr <= 0; m_cnt <= 0; m_wrap <= 1'b0;
            m2_lane <= init_vals[31:0]; m2_cap <= init_vals[31:0]; m2_cnt <= 0; m2_wrap <= 1'b0;
        end else begin
            m_wrap  <= upd_valid && m_ptr == 3;
            m2_wrap <= upd_valid;
            if (upd_valid) begin
                m_lane[m_ptr] <= upd_state;
                m_ptr         <= (m_ptr + 1) % 4;
                m_cnt         <= (m_cnt == 65535) ? m_cnt : m_cnt + 1;
                m2_lane       <= upd_state;
                m2_cnt        <= (m2_cnt == 3) ? m2_cnt : m2_cnt + 1;
            end
        end
    end

    function automatic bit m_final();
        bit ok = (m_ptr == 0) && (m_cnt != 0);
        for (int i = 0; i < 4; i++) ok = ok && (m_lane[i] == m_cap[i]);
        return FIN && ok;
    endfunction

    // compare every DUT output against the model once per cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("upd_ready", upd_ready, !rst && !init);
            chk("cur_lane", cur_lane, m_ptr);
            chk("cur_state", cur_state, m_lane[m_ptr]);
            chk("cur_renorm", cur_renorm, m_lane[m_ptr] < RL);
            chk("lane_wrap", lane_wrap, m_wrap);
            chk("upd_count", upd_count, m_cnt);
            chk("final_ok", final_ok, m_final());
            chk("n1_upd_ready", upd_ready2, !rst && !init);
            chk("n1_cur_lane", cur_lane2, 0);
            chk("n1_cur_state", cur_state2, m2_lane);
            chk("n1_cur_renorm", cur_renorm2, m2_lane < RL);
            chk("n1_lane_wrap", lane_wrap2, m2_wrap);
            chk("n1_upd_count", upd_count2, m2_cnt);
            chk("n1_final_ok", final_ok2, FIN && m2_lane == m2_cap && m2_cnt != 0);
        end
    end

    task automatic cyc(input bit r, input bit i, input bit v, input logic [31:0] s);
        @(posedge clk);
        #1;
        rst = r; init = i; upd_valid = v; upd_state = s;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; init = 1'b0; upd_valid = 1'b0; upd_state = 32'd0;
        init_vals = {32'h4, 32'h3, 32'h2, 32'h1};
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        settle();
        chk("lit_reset_lane", cur_lane, 0);
        chk("lit_reset_state", cur_state, 0);
        chk("lit_reset_count", upd_count, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        settle();
        chk("lit_init_state", cur_state, 32'h1);
        chk("lit_init_count", upd_count, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 32'hA0 + i);
        cyc(0, 0, 0, 0);
        settle();
        chk("lit_b2b_wrap", lane_wrap, 1);
        chk("lit_b2b_count", upd_count, 4);
        chk("lit_b2b_lane", cur_lane, 0);
        chk("lit_b2b_state", cur_state, 32'hA0);
        chk("lit_n1_sat", upd_count2, 3);
        cyc(0, 0, 0, 0);
        settle();
        chk("lit_wrap_clear", lane_wrap, 0);
        cyc(0, 1, 1, 32'h55);
        settle();
        chk("lit_init_ready", upd_ready, 0);
        cyc(0, 0, 0, 0);
        settle();
        chk("lit_init_drop_state", cur_state, 32'h1);
        chk("lit_init_drop_count", upd_count, 0);
        cyc(0, 0, 1, 32'h77);
        cyc(1, 0, 1, 32'h66);
        settle();
        chk("lit_rst_ready", upd_ready, 0);
        cyc(0, 0, 0, 0);
        settle();
        chk("lit_rst_state", cur_state, 0);
        chk("lit_rst_count", upd_count, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, RL - 1);
        cyc(0, 0, 1, 32'hFFFF_FFFF);
        cyc(0, 0, 1, 32'h0);
        cyc(0, 0, 1, RL);
        cyc(0, 0, 0, 0);
        settle();
        chk("lit_renorm_below", cur_renorm, 1);
        chk("lit_renorm_state", cur_state, RL - 1);
        cyc(0, 0, 1, RL);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        settle();
        chk("lit_gap_lane", cur_lane, 1);
        chk("lit_gap_state", cur_state, 32'hFFFF_FFFF);
        for (int i = 1; i < 4; i++) cyc(0, 0, 1, i);
        cyc(0, 0, 0, 0);
        settle();
        chk("lit_renorm_at_l", cur_renorm, 0);
        chk("lit_renorm_count", upd_count, 8);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 32'hB0 + i);
        cyc(0, 0, 0, 0);
        settle();
        chk("lit_sat_count", upd_count, 5);
        chk("lit_sat_n1_count", upd_count2, 3);
        chk("lit_sat_lane_state", cur_state, 32'hB1);
        chk("lit_n1_state", cur_state2, 32'hB4);
        cyc(0, 1, 0, 0);
        for (int i = 1; i <= 4; i++) cyc(0, 0, 1, i);
        cyc(0, 0, 0, 0);
        settle();
        chk("lit_final_good", final_ok, FIN);
        for (int i = 1; i <= 4; i++) cyc(0, 0, 1, (i == 4) ? 32'h5 : i);
        cyc(0, 0, 0, 0);
        settle();
        chk("lit_final_off", final_ok, 0);
        for (int n = 0; n < 80; n++)
            cyc(0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) ? RL - 2 + $urandom_range(0, 3) : $urandom);
        cyc(0, 0, 0, 0);
        settle();
        settle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
